// File: rtl/terminal_writer_pkg.sv
// Shared constants, state encoding and row arithmetic helpers for the
// terminal_writer character front end.
package terminal_writer_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 25;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 7;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR_SCREEN = 2'd0,
    ST_IDLE         = 2'd1,
    ST_CLEAR_LINE   = 2'd2
  } tw_state_e;

  // Next physical row with wrap at the VRAM row count.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r,
                                               input logic [ROW_W:0]   rows);
    if ({1'b0, r} == (rows - 6'd1)) begin
      row_inc = {ROW_W{1'b0}};
    end else begin
      row_inc = r + 5'd1;
    end
  endfunction

  // (top + cur) mod rows by compare-and-subtract; both operands are < rows.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                input logic [ROW_W-1:0] cur,
                                                input logic [ROW_W:0]   rows);
    logic [ROW_W:0] sum;
    sum = {1'b0, top} + {1'b0, cur};
    if (sum >= rows) begin
      sum = sum - rows;
    end else begin
      sum = sum;
    end
    phys_row = sum[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/terminal_writer_clear_sweep.sv
// Row-major row/col counter used for both the single-line and full-screen
// blank fills. The current position is valid in the start cycle itself.
module clear_sweep
  import terminal_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic             start,
  input  logic [ROW_W-1:0] base_row,
  input  logic [ROW_W:0]   row_count,
  output logic             valid,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done
);

  localparam logic [COL_W-1:0] LAST_COL = 7'(COLS - 1);
  localparam logic [ROW_W:0]   ROWS_W   = 6'(ROWS);

  logic             busy_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic [ROW_W:0]   left_r;
  logic [ROW_W:0]   left_s;

  // Present the start position directly so the first write needs no extra cycle.
  always_comb begin
    if (start) begin
      row    = base_row;
      col    = {COL_W{1'b0}};
      left_s = row_count;
    end else begin
      row    = row_r;
      col    = col_r;
      left_s = left_r;
    end
    valid = start | busy_r;
    done  = valid && (col == LAST_COL) && (left_s == 6'd1);
  end

  // Advance one column per valid cycle, stepping rows at the line end.
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      busy_r <= 1'b0;
      row_r  <= {ROW_W{1'b0}};
      col_r  <= {COL_W{1'b0}};
      left_r <= {(ROW_W+1){1'b0}};
    end else if (valid) begin
      if (col == LAST_COL) begin
        col_r  <= {COL_W{1'b0}};
        row_r  <= row_inc(row, ROWS_W);
        left_r <= left_s - 6'd1;
        busy_r <= (left_s != 6'd1);
      end else begin
        col_r  <= col + 7'd1;
        row_r  <= row;
        left_r <= left_s;
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= busy_r;
    end
  end

endmodule

// File: rtl/terminal_writer.sv
// Byte-stream terminal front end: interprets printable/control characters,
// owns the VRAM write port, the cursor and the hardware scroll origin.
module terminal_writer
  import terminal_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic [ROW_W-1:0] top_row,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             write_ce,
  output logic [ROW_W-1:0] write_row,
  output logic [COL_W-1:0] write_col,
  output logic [7:0]       write_char
);

  localparam logic [COL_W-1:0] LAST_COL = 7'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_W   = 6'(ROWS);

  tw_state_e        state_r, state_s;
  logic [ROW_W-1:0] top_row_r, top_row_s;
  logic [ROW_W-1:0] cursor_row_r, cursor_row_s;
  logic [COL_W-1:0] cursor_col_r, cursor_col_s;
  logic [ROW_W-1:0] line_base_r, line_base_s;
  logic             pend_r, pend_s;
  logic             last_r;

  logic             write_ce_r, write_ce_s;
  logic [ROW_W-1:0] write_row_r, write_row_s;
  logic [COL_W-1:0] write_col_r, write_col_s;
  logic [7:0]       write_char_r, write_char_s;

  logic             sw_start_s;
  logic [ROW_W-1:0] sw_base_s;
  logic [ROW_W:0]   sw_count_s;
  logic             sw_valid_s;
  logic [ROW_W-1:0] sw_row_s;
  logic [COL_W-1:0] sw_col_s;
  logic             sw_done_s;

  logic             accept_s;
  logic             printable_s;
  logic             newline_s;
  logic             defer_s;
  logic [ROW_W-1:0] phys_row_s;

  assign in_ready    = (state_r == ST_IDLE);
  assign accept_s    = in_valid && (state_r == ST_IDLE);
  assign printable_s = (in_char >= CH_SPACE) && (in_char <= CH_TILDE);
  assign phys_row_s  = phys_row(top_row_r, cursor_row_r, ROWS_W);

  assign top_row    = top_row_r;
  assign cursor_row = cursor_row_r;
  assign cursor_col = cursor_col_r;
  assign write_ce   = write_ce_r;
  assign write_row  = write_row_r;
  assign write_col  = write_col_r;
  assign write_char = write_char_r;

  clear_sweep #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sweep (
    .clk       (clk),
    .reset_low (reset_low),
    .start     (sw_start_s),
    .base_row  (sw_base_s),
    .row_count (sw_count_s),
    .valid     (sw_valid_s),
    .row       (sw_row_s),
    .col       (sw_col_s),
    .done      (sw_done_s)
  );

  // Next state, cursor/scroll updates and sweep launch.
  always_comb begin
    state_s      = state_r;
    top_row_s    = top_row_r;
    cursor_row_s = cursor_row_r;
    cursor_col_s = cursor_col_r;
    line_base_s  = line_base_r;
    pend_s       = pend_r;
    sw_start_s   = 1'b0;
    sw_base_s    = {ROW_W{1'b0}};
    sw_count_s   = 6'd1;
    newline_s    = 1'b0;
    defer_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (printable_s) begin
            // A wrap-triggered clear waits one cycle so the printable lands first.
            if (cursor_col_r == LAST_COL) begin
              cursor_col_s = {COL_W{1'b0}};
              newline_s    = 1'b1;
              defer_s      = 1'b1;
            end else begin
              cursor_col_s = cursor_col_r + 7'd1;
            end
          end else begin
            case (in_char)
              CH_CR: cursor_col_s = {COL_W{1'b0}};
              CH_LF: newline_s = 1'b1;
              CH_BS: begin
                if (cursor_col_r != 7'd0) begin
                  cursor_col_s = cursor_col_r - 7'd1;
                end else begin
                  cursor_col_s = cursor_col_r;
                end
              end
              CH_FF: begin
                state_s    = ST_CLEAR_SCREEN;
                sw_start_s = 1'b1;
                sw_base_s  = {ROW_W{1'b0}};
                sw_count_s = ROWS_W;
              end
              default: cursor_col_s = cursor_col_r;
            endcase
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
        if (pend_r) begin
          pend_s     = 1'b0;
          sw_start_s = 1'b1;
          if (state_r == ST_CLEAR_LINE) begin
            sw_base_s  = line_base_r;
            sw_count_s = 6'd1;
          end else begin
            sw_base_s  = {ROW_W{1'b0}};
            sw_count_s = ROWS_W;
          end
        end else begin
          pend_s = 1'b0;
        end
        // last_r marks the cycle after the final blank write.
        if (last_r) begin
          state_s = ST_IDLE;
          if (state_r == ST_CLEAR_SCREEN) begin
            top_row_s    = {ROW_W{1'b0}};
            cursor_row_s = {ROW_W{1'b0}};
            cursor_col_s = {COL_W{1'b0}};
          end else begin
            top_row_s = top_row_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_CLEAR_SCREEN;
        pend_s  = 1'b1;
      end
    endcase

    // Bottom-row newline scrolls: the old top row becomes the new bottom line.
    if (newline_s) begin
      if (cursor_row_r != LAST_ROW) begin
        cursor_row_s = cursor_row_r + 5'd1;
      end else begin
        top_row_s = row_inc(top_row_r, ROWS_W);
        state_s   = ST_CLEAR_LINE;
        if (defer_s) begin
          pend_s      = 1'b1;
          line_base_s = top_row_r;
        end else begin
          sw_start_s = 1'b1;
          sw_base_s  = top_row_r;
          sw_count_s = 6'd1;
        end
      end
    end else begin
      cursor_row_s = cursor_row_s;
    end
  end

  // Write-port source select: accepted printable or the blank sweep.
  always_comb begin
    write_ce_s   = 1'b0;
    write_row_s  = write_row_r;
    write_col_s  = write_col_r;
    write_char_s = write_char_r;
    if (accept_s && printable_s) begin
      write_ce_s   = 1'b1;
      write_row_s  = phys_row_s;
      write_col_s  = cursor_col_r;
      write_char_s = in_char;
    end else if (sw_valid_s) begin
      write_ce_s   = 1'b1;
      write_row_s  = sw_row_s;
      write_col_s  = sw_col_s;
      write_char_s = CH_SPACE;
    end else begin
      write_ce_s = 1'b0;
    end
  end

  // State and output registers; reset restarts the full-screen clear.
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      state_r      <= ST_CLEAR_SCREEN;
      top_row_r    <= {ROW_W{1'b0}};
      cursor_row_r <= {ROW_W{1'b0}};
      cursor_col_r <= {COL_W{1'b0}};
      line_base_r  <= {ROW_W{1'b0}};
      pend_r       <= 1'b1;
      last_r       <= 1'b0;
      write_ce_r   <= 1'b0;
      write_row_r  <= {ROW_W{1'b0}};
      write_col_r  <= {COL_W{1'b0}};
      write_char_r <= 8'h00;
    end else begin
      state_r      <= state_s;
      top_row_r    <= top_row_s;
      cursor_row_r <= cursor_row_s;
      cursor_col_r <= cursor_col_s;
      line_base_r  <= line_base_s;
      pend_r       <= pend_s;
      last_r       <= sw_done_s;
      write_ce_r   <= write_ce_s;
      write_row_r  <= write_row_s;
      write_col_r  <= write_col_s;
      write_char_r <= write_char_s;
    end
  end

endmodule

// File: tb/tb_terminal_writer.sv
// Self-checking bench for terminal_writer: a reference model pushes expected
// VRAM writes into a queue that is drained as write_ce pulses appear.
module tb_terminal_writer;

  logic       clk = 1'b0;
  logic       reset_low;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [4:0] top_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;
  logic       write_ce;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_char;

  always #5 clk = ~clk;

  terminal_writer dut (
    .clk        (clk),
    .reset_low  (reset_low),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .top_row    (top_row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .write_ce   (write_ce),
    .write_row  (write_row),
    .write_col  (write_col),
    .write_char (write_char)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = -10;
  int prev_wr_cyc = -10;
  logic [19:0] exp_q[$];
  int m_top = 0;
  int m_row = 0;
  int m_col = 0;

  // One clock; outputs sampled on the falling edge, writes checked against the queue.
  task automatic tick();
    logic [19:0] got;
    logic [19:0] exp;
    @(negedge clk);
    cyc++;
    if (write_ce === 1'b1) begin
      got = {write_row, write_col, write_char};
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got row=%0d col=%0d char=%02h, required no write",
                 got[19:15], got[14:8], got[7:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write: got row=%0d col=%0d char=%02h, required row=%0d col=%0d char=%02h",
                   got[19:15], got[14:8], got[7:0], exp[19:15], exp[14:8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic push_write(input int r, input int c, input logic [7:0] ch);
    exp_q.push_back({5'(r), 7'(c), ch});
  endtask

  task automatic push_screen();
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 80; c++)
        push_write(r, c, 8'h20);
  endtask

  task automatic model_newline();
    if (m_row < 24) begin
      m_row++;
    end else begin
      for (int c = 0; c < 80; c++) push_write(m_top, c, 8'h20);
      m_top = (m_top + 1) % 25;
    end
  endtask

  task automatic model_byte(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_write((m_top + m_row) % 25, m_col, ch);
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        model_newline();
      end
    end else begin
      case (ch)
        8'h0D: m_col = 0;
        8'h0A: model_newline();
        8'h08: if (m_col > 0) m_col--;
        8'h0C: begin
          push_screen();
          m_top = 0; m_row = 0; m_col = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    model_byte(ch);
    in_valid = 1'b1;
    in_char  = ch;
    n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic test_reset();
    reset_low = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", in_ready); end
    checks++; if (write_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b required 0", write_ce); end
    checks++; if ({top_row, cursor_row, cursor_col} !== 17'd0) begin errors++;
      $display("FAIL reset_pos: got top=%0d row=%0d col=%0d required 0/0/0", top_row, cursor_row, cursor_col); end
    m_top = 0; m_row = 0; m_col = 0;
    push_screen();
    reset_low = 1'b1;
    wait_idle();
    checks++; if (cyc - last_wr_cyc !== 1) begin errors++;
      $display("FAIL reset_ready_gap: got %0d cycles after last clear, required 1", cyc - last_wr_cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL reset_clears: got %0d missing writes, required 0", exp_q.size()); end
    checks++; if ({top_row, cursor_row, cursor_col} !== 17'd0) begin errors++;
      $display("FAIL reset_home: got top=%0d row=%0d col=%0d required 0/0/0", top_row, cursor_row, cursor_col); end
  endtask

  task automatic test_back_to_back();
    send(8'h41);
    send(8'h42);
    checks++; if (last_wr_cyc - prev_wr_cyc !== 1) begin errors++;
      $display("FAIL b2b_gap: got %0d cycles between writes, required 1", last_wr_cyc - prev_wr_cyc); end
    checks++; if (cursor_col !== 7'd2) begin errors++; $display("FAIL b2b_col: got %0d required 2", cursor_col); end
  endtask

  task automatic test_wrap();
    send(8'h0D);
    for (int i = 0; i < 80; i++) send(8'h78);
    send(8'h79);
    checks++; if (cursor_row !== 5'd1 || cursor_col !== 7'd1) begin errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d) required (1,1)", cursor_row, cursor_col); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 23; i++) send(8'h0A);
    checks++; if (cursor_row !== 5'd24) begin errors++; $display("FAIL scroll_row_pre: got %0d required 24", cursor_row); end
    send(8'h0A);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scroll_ready_drop: got %b required 0", in_ready); end
    checks++; if (last_wr_cyc !== cyc) begin errors++;
      $display("FAIL scroll_first_clear: got last write at cycle %0d, required %0d", last_wr_cyc, cyc); end
    wait_idle();
    checks++; if (cyc - last_wr_cyc !== 1) begin errors++;
      $display("FAIL scroll_ready_gap: got %0d required 1", cyc - last_wr_cyc); end
    checks++; if (top_row !== 5'd1 || cursor_row !== 5'd24 || cursor_col !== 7'd1) begin errors++;
      $display("FAIL scroll_state: got top=%0d row=%0d col=%0d required 1/24/1", top_row, cursor_row, cursor_col); end
    send(8'h5A);
    checks++; if (cursor_col !== 7'd2) begin errors++; $display("FAIL scroll_z_col: got %0d required 2", cursor_col); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scroll_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap_scroll();
    send(8'h0D);
    for (int i = 0; i < 80; i++) send(8'h77);
    wait_idle();
    checks++; if (top_row !== 5'd2 || cursor_row !== 5'd24 || cursor_col !== 7'd0) begin errors++;
      $display("FAIL wrap_scroll_state: got top=%0d row=%0d col=%0d required 2/24/0", top_row, cursor_row, cursor_col); end
    send(8'h0A);
    wait_idle();
    checks++; if (top_row !== 5'd3) begin errors++; $display("FAIL wrap_scroll_top: got %0d required 3", top_row); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_scroll_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_controls();
    send(8'h0D);
    send(8'h08);
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd24) begin errors++;
      $display("FAIL bs_col0: got (%0d,%0d) required (24,0)", cursor_row, cursor_col); end
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h08);
    checks++; if (cursor_col !== 7'd4) begin errors++; $display("FAIL bs_col5: got %0d required 4", cursor_col); end
    send(8'h07);
    checks++; if (cursor_col !== 7'd4 || cursor_row !== 5'd24 || top_row !== 5'd3) begin errors++;
      $display("FAIL bell_ignored: got top=%0d row=%0d col=%0d required 3/24/4", top_row, cursor_row, cursor_col); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ctrl_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_form_feed();
    send(8'h0C);
    wait_idle();
    checks++; if (cyc - last_wr_cyc !== 1) begin errors++;
      $display("FAIL ff_ready_gap: got %0d required 1", cyc - last_wr_cyc); end
    checks++; if ({top_row, cursor_row, cursor_col} !== 17'd0) begin errors++;
      $display("FAIL ff_home: got top=%0d row=%0d col=%0d required 0/0/0", top_row, cursor_row, cursor_col); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ff_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 24; i++) send(8'h0A);
    send(8'h0A);
    repeat (10) tick();
    exp_q.delete();
    reset_low = 1'b0;
    repeat (2) tick();
    checks++; if (write_ce !== 1'b0 || in_ready !== 1'b0 || top_row !== 5'd0) begin errors++;
      $display("FAIL midreset_outputs: got ce=%b ready=%b top=%0d required 0/0/0", write_ce, in_ready, top_row); end
    m_top = 0; m_row = 0; m_col = 0;
    push_screen();
    reset_low = 1'b1;
    wait_idle();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midreset_clears: got %0d missing, required 0", exp_q.size()); end
    checks++; if ({top_row, cursor_row, cursor_col} !== 17'd0) begin errors++;
      $display("FAIL midreset_home: got top=%0d row=%0d col=%0d required 0/0/0", top_row, cursor_row, cursor_col); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_scroll();
    test_wrap_scroll();
    test_controls();
    test_form_feed();
    test_reset_mid_clear();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
